change_dispenser: RTL

- Consumer side of the drink machine's change interface.
- Takes single-cycle change requests (nickel, dime, two-dime) and queues them as pending coin counts.
- Drives two physical coin hoppers (nickel, dime) with an eject/sensed handshake and tracks each hopper's inventory.
- Substitutes two nickels for a dime when the dime hopper is empty; flags shortfall, overflow and hopper jams.

---
 rtl/change_dispenser.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: queues nickel/dime change requests and drives two coin hoppers
// through an eject/sensed handshake, tracking inventory, shortfall, overflow and jams.
module change_dispenser #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned PEND_W     = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned LOW_THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             nickel_req,
    input  logic             dime_req,
    input  logic             two_dime_req,
    output logic             nickel_eject,
    input  logic             nickel_sensed,
    output logic             dime_eject,
    input  logic             dime_sensed,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] load_nickels,
    input  logic [CNT_W-1:0] load_dimes,
    output logic [CNT_W-1:0] nickel_count,
    output logic [CNT_W-1:0] dime_count,
    output logic             nickel_low,
    output logic             dime_low,
    output logic             busy,
    output logic             shortfall,
    output logic             req_overflow,
    output logic             fault
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned PSUM_W = PEND_W + 2;
    localparam int unsigned CSUM_W = CNT_W + 2;

    typedef enum logic [1:0] {IDLE, WAIT_N, WAIT_D, FAULT} state_t;

    state_t            state, state_next;
    logic [PEND_W-1:0] pend_n, pend_d, pend_n_next, pend_d_next;
    logic [TMR_W-1:0]  timer;
    logic [CNT_W-1:0]  nickel_count_next, dime_count_next;
    logic [1:0]        inc_n, inc_d;
    logic              pay_n, pay_d, sub_d, short_n, short_d;
    logic              ovf_n, ovf_d;

    // Net pending update: current + requests - served, saturating with overflow flag
    function automatic logic [PEND_W-1:0] pend_upd(input logic [PEND_W-1:0] cur,
                                                    input logic [1:0] inc,
                                                    input logic dec,
                                                    output logic ovf);
        logic [PSUM_W-1:0] sum;
        sum = PSUM_W'(cur) + PSUM_W'(inc) - PSUM_W'(dec);
        ovf = (sum > PSUM_W'({PEND_W{1'b1}}));
        return ovf ? {PEND_W{1'b1}} : PEND_W'(sum);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] cur,
                                                  input logic [CNT_W-1:0] add,
                                                  input logic dec);
        logic [CSUM_W-1:0] sum;
        sum = CSUM_W'(cur) + CSUM_W'(add) - CSUM_W'(dec);
        return (sum > CSUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(sum);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state plus the one-per-cycle IDLE decision strobes
    always_comb begin
        state_next = state;
        pay_n      = 1'b0;
        pay_d      = 1'b0;
        sub_d      = 1'b0;
        short_n    = 1'b0;
        short_d    = 1'b0;
        case (state)
            IDLE: begin
                if (pend_d != '0) begin
                    if (dime_count != '0)                  state_next = WAIT_D;
                    else if (nickel_count >= CNT_W'(2))    sub_d      = 1'b1;
                    else                                   short_d    = 1'b1;
                end else if (pend_n != '0) begin
                    if (nickel_count != '0)                state_next = WAIT_N;
                    else                                   short_n    = 1'b1;
                end
            end
            WAIT_N: begin
                if (nickel_sensed) begin
                    pay_n      = 1'b1;
                    state_next = IDLE;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    state_next = FAULT;
                end
            end
            WAIT_D: begin
                if (dime_sensed) begin
                    pay_d      = 1'b1;
                    state_next = IDLE;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    state_next = FAULT;
                end
            end
            default: state_next = FAULT;
        endcase
    end

    // Datapath next values; a dime substitution queues two extra nickels
    always_comb begin
        inc_n = 2'(nickel_req) + (sub_d ? 2'd2 : 2'd0);
        inc_d = 2'(dime_req) + (two_dime_req ? 2'd2 : 2'd0);
        ovf_n = 1'b0;
        ovf_d = 1'b0;
        pend_n_next = pend_upd(pend_n, inc_n, pay_n | short_n, ovf_n);
        pend_d_next = pend_upd(pend_d, inc_d, pay_d | sub_d | short_d, ovf_d);
        nickel_count_next = cnt_upd(nickel_count, load_valid ? load_nickels : {CNT_W{1'b0}}, pay_n);
        dime_count_next   = cnt_upd(dime_count, load_valid ? load_dimes : {CNT_W{1'b0}}, pay_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_n       <= '0;
            pend_d       <= '0;
            timer        <= '0;
            nickel_count <= '0;
            dime_count   <= '0;
            nickel_eject <= 1'b0;
            dime_eject   <= 1'b0;
            nickel_low   <= 1'b1;
            dime_low     <= 1'b1;
            busy         <= 1'b0;
            shortfall    <= 1'b0;
            req_overflow <= 1'b0;
            fault        <= 1'b0;
        end else begin
            pend_n       <= pend_n_next;
            pend_d       <= pend_d_next;
            // Timer restarts from zero on every WAIT entry
            timer        <= ((state_next == WAIT_N || state_next == WAIT_D) && state_next == state)
                            ? timer + TMR_W'(1) : '0;
            nickel_count <= nickel_count_next;
            dime_count   <= dime_count_next;
            nickel_eject <= (state_next == WAIT_N);
            dime_eject   <= (state_next == WAIT_D);
            nickel_low   <= (nickel_count_next <= CNT_W'(LOW_THRESH));
            dime_low     <= (dime_count_next <= CNT_W'(LOW_THRESH));
            busy         <= (state_next != IDLE) || (pend_n_next != '0) || (pend_d_next != '0);
            shortfall    <= shortfall | short_n | short_d;
            req_overflow <= req_overflow | ovf_n | ovf_d;
            fault        <= fault | (state_next == FAULT);
        end
    end

endmodule
